// File: rtl/qed_dup_if.sv
// Instruction-in / beat-out handshake bundle for the QED duplicating decoder.
// master = upstream/downstream environment, slave = decoder.
interface qed_dup_if #(
    parameter int CNT_W = 16
);
    logic             qed_en;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_is_dup;
    logic [1:0]       out_class;
    logic             qed_viol;
    logic [CNT_W-1:0] dup_cnt;

    modport master (
        output qed_en, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, out_is_dup, out_class, qed_viol, dup_cnt
    );

    modport slave (
        input  qed_en, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, out_is_dup, out_class, qed_viol, dup_cnt
    );
endinterface

// File: rtl/qed_dup_decoder.sv
// QED duplicating decoder: emits each RV32 instruction and, when eligible, a
// register/memory-offset duplicate of it as a second beat.
module qed_dup_decoder #(
    parameter int          REG_OFFSET = 16,
    parameter logic [11:0] MEM_OFFSET = 12'h400,
    parameter int          CNT_W      = 16
) (
    input  logic      clk,
    input  logic      reset_x,
    qed_dup_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ORIG, DUP} state_t;

    localparam logic [5:0] LP_OFF = 6'(REG_OFFSET);

    state_t           r_state;
    logic             r_out_valid;
    logic [31:0]      r_out_instr;
    logic             r_is_dup;
    logic [1:0]       r_class;
    logic             r_pend;
    logic             r_viol;
    logic [CNT_W-1:0] r_dup_cnt;
    logic [31:0]      r_dup_instr;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_ld;
    logic        w_is_st;
    logic [1:0]  w_class;
    logic        w_use_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_in_range;
    logic        w_elig;
    logic [11:0] w_ld_imm;
    logic [11:0] w_st_imm;
    logic [31:0] w_dup_instr;
    logic        w_accept;

    assign w_op  = bus.in_instr[6:0];
    assign w_f3  = bus.in_instr[14:12];
    assign w_rd  = bus.in_instr[11:7];
    assign w_rs1 = bus.in_instr[19:15];
    assign w_rs2 = bus.in_instr[24:20];

    assign w_is_r  = (w_op == 7'b0110011);
    assign w_is_i  = (w_op == 7'b0010011);
    assign w_is_ld = (w_op == 7'b0000011) && (w_f3 == 3'b010);
    assign w_is_st = (w_op == 7'b0100011) && (w_f3 == 3'b010);

    assign w_class = w_is_r ? 2'b01 :
                     w_is_i ? 2'b10 :
                     (w_is_ld || w_is_st) ? 2'b11 : 2'b00;

    // Only true register fields take part; shamt/immediate bits never do.
    assign w_use_rd  = w_is_r || w_is_i || w_is_ld;
    assign w_use_rs1 = (w_class != 2'b00);
    assign w_use_rs2 = w_is_r || w_is_st;

    assign w_in_range = !(w_use_rd  && ({1'b0, w_rd}  >= LP_OFF)) &&
                        !(w_use_rs1 && ({1'b0, w_rs1} >= LP_OFF)) &&
                        !(w_use_rs2 && ({1'b0, w_rs2} >= LP_OFF));
    assign w_elig     = bus.qed_en && (w_class != 2'b00);

    assign w_ld_imm = bus.in_instr[31:20] + MEM_OFFSET;
    assign w_st_imm = {bus.in_instr[31:25], bus.in_instr[11:7]} + MEM_OFFSET;

    always_comb begin
        w_dup_instr = bus.in_instr;
        if (w_use_rd && (w_rd != 5'd0))
            w_dup_instr[11:7] = w_rd + LP_OFF[4:0];
        if (w_use_rs1 && (w_rs1 != 5'd0))
            w_dup_instr[19:15] = w_rs1 + LP_OFF[4:0];
        if (w_use_rs2 && (w_rs2 != 5'd0))
            w_dup_instr[24:20] = w_rs2 + LP_OFF[4:0];
        if (w_is_ld)
            w_dup_instr[31:20] = w_ld_imm;
        if (w_is_st) begin
            w_dup_instr[31:25] = w_st_imm[11:5];
            w_dup_instr[11:7]  = w_st_imm[4:0];
        end
    end

    // in_ready is forced low during reset and blocked while a duplicate is owed.
    assign bus.in_ready = reset_x &&
                          ((r_state == IDLE) ||
                           ((r_state == ORIG) && bus.out_ready && !r_pend) ||
                           ((r_state == DUP)  && bus.out_ready));
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign bus.qed_viol   = (r_state == ORIG) && r_viol && bus.out_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_instr  = r_out_instr;
    assign bus.out_is_dup = r_is_dup;
    assign bus.out_class  = r_class;
    assign bus.dup_cnt    = r_dup_cnt;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_is_dup    <= 1'b0;
            r_class     <= 2'b00;
            r_pend      <= 1'b0;
            r_viol      <= 1'b0;
            r_dup_cnt   <= '0;
        end else begin
            if ((r_state == DUP) && bus.out_ready && (r_dup_cnt != '1))
                r_dup_cnt <= r_dup_cnt + 1'b1;

            if ((r_state == ORIG) && bus.out_ready && r_pend) begin
                r_state     <= DUP;
                r_out_instr <= r_dup_instr;
                r_is_dup    <= 1'b1;
                r_pend      <= 1'b0;
                r_viol      <= 1'b0;
            end else if (w_accept) begin
                r_state     <= ORIG;
                r_out_valid <= 1'b1;
                r_out_instr <= bus.in_instr;
                r_is_dup    <= 1'b0;
                r_class     <= w_class;
                r_pend      <= w_elig && w_in_range;
                r_viol      <= w_elig && !w_in_range;
            end else if ((r_state != IDLE) && bus.out_ready) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_viol      <= 1'b0;
            end
        end
    end

    // Duplicate word is pure data; it is only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_dup_instr <= w_dup_instr;
    end
endmodule

// File: tb/tb_qed_dup_decoder.sv
// Scoreboard bench for qed_dup_decoder: randomized and directed instructions,
// expected beats from a field-level reference model, checked by a monitor.
module tb_qed_dup_decoder;
    localparam int          REG_OFF = 16;
    localparam int          MEM_OFF = 'h400;

    typedef struct {
        logic [31:0] instr;
        logic        dup;
        logic [1:0]  cls;
        logic        viol;
        logic        has_dup;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_x = 1'b1;
    logic        qed_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic        out_ready = 1'b1;
    int          mode = 0;

    beat_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_cnt = 0;
    bit    hold = 0;
    logic [31:0] h_instr;
    logic        h_dup;
    logic [1:0]  h_cls;

    qed_dup_if #(.CNT_W(16)) bus0 ();
    qed_dup_if #(.CNT_W(2))  bus1 ();

    assign bus0.qed_en    = qed_en;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_instr  = in_instr;
    assign bus0.out_ready = out_ready;
    assign bus1.qed_en    = qed_en;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_instr  = in_instr;
    assign bus1.out_ready = out_ready;

    qed_dup_decoder #(.CNT_W(16)) u_dut (.clk(clk), .reset_x(reset_x), .bus(bus0));
    qed_dup_decoder #(.CNT_W(2))  u_dut2 (.clk(clk), .reset_x(reset_x), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: decodes fields and applies the duplication rules directly.
    function automatic void model_push(input logic [31:0] ins, input logic en);
        logic [6:0]  op  = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        int          rd  = int'(ins[11:7]);
        int          rs1 = int'(ins[19:15]);
        int          rs2 = int'(ins[24:20]);
        bit          is_r = (op == 7'h33);
        bit          is_i = (op == 7'h13);
        bit          is_l = (op == 7'h03) && (f3 == 3'd2);
        bit          is_s = (op == 7'h23) && (f3 == 3'd2);
        logic [1:0]  cls = is_r ? 2'd1 : is_i ? 2'd2 : (is_l || is_s) ? 2'd3 : 2'd0;
        bit          u_rd  = is_r || is_i || is_l;
        bit          u_rs1 = (cls != 2'd0);
        bit          u_rs2 = is_r || is_s;
        bit          ok = !(u_rd && rd >= REG_OFF) && !(u_rs1 && rs1 >= REG_OFF) &&
                          !(u_rs2 && rs2 >= REG_OFF);
        bit          elig = en && (cls != 2'd0);
        logic [31:0] d = ins;
        int          imm;
        q.push_back('{ins, 1'b0, cls, elig && !ok, elig && ok});
        if (elig && ok) begin
            if (u_rd  && rd  != 0) d[11:7]  = 5'(rd + REG_OFF);
            if (u_rs1 && rs1 != 0) d[19:15] = 5'(rs1 + REG_OFF);
            if (u_rs2 && rs2 != 0) d[24:20] = 5'(rs2 + REG_OFF);
            if (is_l) d[31:20] = 12'((int'(ins[31:20]) + MEM_OFF) % 4096);
            if (is_s) begin
                imm = (int'({ins[31:25], ins[11:7]}) + MEM_OFF) % 4096;
                d[31:25] = 7'(imm >> 5);
                d[11:7]  = 5'(imm & 31);
            end
            q.push_back('{d, 1'b1, cls, 1'b0, 1'b0});
        end
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 4))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;
            default: ;
        endcase
        if ($urandom % 5 != 0) r[14:12] = 3'd2;
        if ($urandom % 10 < 7) begin
            r[11:7]  = r[11:7]  & 5'h0f;
            r[19:15] = r[19:15] & 5'h0f;
            r[24:20] = r[24:20] & 5'h0f;
        end
        if ($urandom % 5 == 0) r[11:7]  = 5'd0;
        if ($urandom % 5 == 0) r[19:15] = 5'd0;
        return r;
    endfunction

    task automatic send(input logic [31:0] ins, input logic en, input bit dir = 0,
                        input logic [31:0] d_dup = 32'd0, input logic [1:0] d_cls = 2'd0,
                        input bit d_has = 0, input bit d_viol = 0);
        in_valid = 1'b1;
        in_instr = ins;
        qed_en   = en;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                if (dir) begin
                    q.push_back('{ins, 1'b0, d_cls, d_viol, d_has});
                    if (d_has) q.push_back('{d_dup, 1'b1, d_cls, 1'b0, 1'b0});
                end else begin
                    model_push(ins, en);
                end
                @(posedge clk); #2;
                in_valid = 1'b0;
                in_instr = $urandom;
                qed_en   = 1'($urandom);
                return;
            end
            @(posedge clk); #2;
        end
        n_vec++; n_err++;
        $display("FAIL accept_timeout: got in_ready low for 200 cycles, expected accept");
        in_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = ($urandom % 4) != 0;
        endcase
    end

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        beat_t b;
        logic  exp_ir;
        if (!reset_x) begin
            hold = 0;
        end else begin
            chk("dup_cnt", 32'(bus0.dup_cnt), (exp_cnt > 65535) ? 65535 : exp_cnt);
            chk("dup_cnt_w2", 32'(bus1.dup_cnt), (exp_cnt > 3) ? 3 : exp_cnt);
            if (hold) begin
                chk("hold_instr", bus0.out_instr, h_instr);
                chk("hold_dup", 32'(bus0.out_is_dup), 32'(h_dup));
                chk("hold_class", 32'(bus0.out_class), 32'(h_cls));
            end
            exp_ir = !bus0.out_valid ||
                     (out_ready && !(q.size() > 0 && !q[0].dup && q[0].has_dup));
            chk("in_ready", 32'(bus0.in_ready), 32'(exp_ir));
            if (bus0.out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got %h expected no beat", bus0.out_instr);
                end else begin
                    b = q.pop_front();
                    chk("out_instr", bus0.out_instr, b.instr);
                    chk("out_is_dup", 32'(bus0.out_is_dup), 32'(b.dup));
                    chk("out_class", 32'(bus0.out_class), 32'(b.cls));
                    chk("qed_viol", 32'(bus0.qed_viol), 32'(b.viol));
                    if (b.dup) exp_cnt++;
                end
            end else begin
                chk("qed_viol_quiet", 32'(bus0.qed_viol), 32'd0);
            end
            hold    = bus0.out_valid && !out_ready;
            h_instr = bus0.out_instr;
            h_dup   = bus0.out_is_dup;
            h_cls   = bus0.out_class;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_x = 1'b0;
        #3;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("rst_out_instr", bus0.out_instr, 32'd0);
        chk("rst_dup_cnt", 32'(bus0.dup_cnt), 32'd0);
        chk("rst_class", 32'(bus0.out_class), 32'd0);
        chk("rst_viol", 32'(bus0.qed_viol), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_x = 1'b1;
        @(posedge clk); #2;

        // ADD x3,x1,x2 ; LW x5,8(x2) ; ADD x20,x1,x2 (out of range)
        send(32'h002081B3, 1'b1, 1, 32'h012889B3, 2'd1, 1, 0);
        send(32'h00812283, 1'b1, 1, 32'h40892A83, 2'd3, 1, 0);
        send(32'h00208A33, 1'b1, 1, 32'd0, 2'd1, 0, 1);
        repeat (4) @(posedge clk); #2;

        // Back-to-back with duplication disabled
        for (int i = 0; i < 8; i++) send(rnd_instr(), 1'b0);
        repeat (3) @(posedge clk); #2;

        // Stall original, then stall duplicate, then reset while in DUP
        mode = 1;
        send(32'h002081B3, 1'b1);
        repeat (3) @(posedge clk); #2;
        mode = 0;
        @(posedge clk); #2;
        mode = 1;
        repeat (3) @(posedge clk); #2;
        reset_x = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("mid_rst_out_instr", bus0.out_instr, 32'd0);
        chk("mid_rst_is_dup", 32'(bus0.out_is_dup), 32'd0);
        chk("mid_rst_dup_cnt", 32'(bus0.dup_cnt), 32'd0);
        q.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk); #2;
        reset_x = 1'b1;
        mode = 0;
        repeat (5) @(posedge clk); #2;

        // Five duplicated instructions walk the narrow counter into saturation
        for (int i = 0; i < 5; i++) send(32'h002081B3, 1'b1);
        repeat (4) @(posedge clk); #2;

        mode = 2;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom % 3) @(posedge clk);
            #0;
            send(rnd_instr(), 1'($urandom));
        end

        mode = 0;
        for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: got %0d beats outstanding expected 0", q.size());
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
